spike_rate_decoder: RTL and testbench
=====================================

# spike_rate_decoder

Spike-to-value decoder for the integrate-and-fire neuron datapath: samples a single-bit spike train, counts spikes over a fixed window of 2^WINDOW_LOG2 clock cycles, and returns an 8-bit rate value, optionally with the last inter-spike interval (ISI). It is the receiving end of the neuron's current-to-spike encoding. It sits between a neuron's `spike` output and downstream logic, such as a readout or host register, that consumes results over a valid/ready handshake.

## Interface
- `WINDOW_LOG2`, default 8: window length N = 2^WINDOW_LOG2 cycles; legal range 2..12.
- `clk`  in  1  clock; all sampling on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `spike`  in  1  spike input; one spike counted per high cycle.
- `enable`  in  1  decoding enabled; low forces IDLE.
- `ready`  in  1  consumer accepts the result when `valid && ready`.
- `valid`  out  1  result registers hold an unconsumed result.
- `rate`  out  8  spikes in the last completed window, saturated at 255.
- `isi`  out  8  cycles between the last two spikes, saturated at 255.
- `overflow`  out  1  sticky flag: a completed window was dropped because the output was still occupied.

## Operation
- FSM states:
  - IDLE: counters held at 0.
  - COUNT: window active.
- Transitions:
  - IDLE→COUNT on a sampled edge with `enable`=1. That cycle is window index 0 and its spike is counted.
  - COUNT→IDLE on any edge with `enable`=0. The partial window is discarded, spike count and ISI counter are cleared, and the output registers, `valid` and `overflow` are untouched.
- Window counter: WINDOW_LOG2 bits, counts 0..N-1 in COUNT, wraps to 0 with no gap cycle.
- Spike counter: 9 bits internally, incremented when `spike`=1 in COUNT. Reported as `rate` = min(count, 255).
- Window end: on the edge sampling index N-1, the counted value includes that cycle's spike. Then:
  - if the output slot is free (`valid`=0, or `valid && ready` in that same cycle), load `rate` and `isi` and hold `valid`=1;
  - otherwise drop the result and set `overflow`=1.
  - In both cases the spike counter restarts at 0, or at 1 if the sampled `spike` belongs to the new window index 0 on the next edge.
- Handshake:
  - `valid` falls on the edge where `valid && ready`, unless a new result loads on that same edge, in which case it stays 1 with the new data.
  - `rate` and `isi` are stable while `valid`=1 and not yet accepted.
- ISI tracking:
  - an 8-bit counter counts cycles since the last spike, saturating at 255;
  - on a spike, `last_isi` is loaded with counter+1 and the counter is cleared;
  - before a second spike has been seen since entering COUNT, `last_isi` = 255.
- `overflow` clears only on reset.

## Timing
- Reset values: `valid`=0, `rate`=0, `isi`=0, `overflow`=0, FSM in IDLE, all counters 0.
- Reset mid-window: everything returns to the reset values immediately; no partial result is emitted.
- Latency: `valid` and the result are visible in the cycle after the edge that sampled window index N-1.
- Back-to-back windows: a new result every N cycles; a consumer with `ready` held at 1 never sees `overflow`.
- Simultaneous window end and accept: the old result is consumed and the new one loaded on the same edge; no drop.
- Combinational paths: none from inputs to outputs; all outputs are registered.

## Configuration
- `SPIKE_DEC_ISI_EN` defined: ISI counter and `last_isi` are implemented, and `isi` reports as described above.
- `SPIKE_DEC_ISI_EN` undefined: ISI logic is removed, `isi` is tied to 0, and rate behaviour is unchanged.

## Test plan
- Reset: assert `rst_n`=0 mid-window with spikes active → all outputs 0 on the next sample; no `valid` after release until a full window with `enable`=1 completes.
- Saturation: WINDOW_LOG2=4, `spike`=1 every cycle, `ready`=1 → `valid` one cycle after the 16th sample, `rate`=16, `isi`=1; repeats every 16 cycles. WINDOW_LOG2=8 with the same stimulus → `rate`=255.
- Periodic spikes: WINDOW_LOG2=4, spike on indices 0, 4, 8, 12 → `rate`=4, `isi`=4 (with ISI_EN). Single spike in the window → `rate`=1, `isi`=255.
- Backpressure: `ready`=0 across two full windows → first result held unchanged; second dropped with `overflow`=1. Then `ready`=1 → first result accepted, `valid`=0, `overflow` stays 1.
- Enable drop: deassert `enable` at index 9 of 16 → no `valid`. Re-enable → next result counts only spikes from the new index 0.
- Accept collision: `ready` pulsed exactly on the window-end edge while `valid`=1 → new data loaded, `valid` stays 1, `overflow`=0.

Source files
------------

// File: rtl/spike_rate_decoder_if.sv
// rtl/spike_rate_decoder_if.sv - spike input and rate-result handshake bundle
interface spike_rate_decoder_if;
  logic       spike;
  logic       enable;
  logic       ready;
  logic       valid;
  logic [7:0] rate;
  logic [7:0] isi;
  logic       overflow;

  modport master (
    output spike, enable, ready,
    input  valid, rate, isi, overflow
  );

  modport slave (
    input  spike, enable, ready,
    output valid, rate, isi, overflow
  );
endinterface

// File: rtl/spike_rate_decoder.sv
// rtl/spike_rate_decoder.sv - windowed spike-rate decoder with valid/ready result slot
// Optional inter-spike interval tracking is built when SPIKE_DEC_ISI_EN is defined.
module spike_rate_decoder #(
  parameter int WINDOW_LOG2 = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spike_rate_decoder_if.slave  bus
);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t                 state, state_nxt;
  logic [WINDOW_LOG2-1:0] win_cnt;
  logic [WINDOW_LOG2-1:0] cur_idx;
  logic [8:0]             spk_cnt;
  logic [9:0]             spk_sum;
  logic                   sample;
  logic                   win_end;
  logic                   slot_free;
  logic [7:0]             rate_nxt;
  logic [7:0]             isi_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.enable)  state_nxt = COUNT;
      COUNT:   if (!bus.enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The enabling edge out of IDLE is itself window index 0.
  always_comb begin
    sample  = bus.enable;
    cur_idx = '0;
    if (state == COUNT) cur_idx = win_cnt;
  end

  assign win_end   = sample && (cur_idx == {WINDOW_LOG2{1'b1}});
  assign slot_free = !bus.valid || bus.ready;
  assign spk_sum   = {1'b0, spk_cnt} + {9'd0, bus.spike};
  assign rate_nxt  = (spk_sum > 10'd255) ? 8'hFF : spk_sum[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt <= '0;
      spk_cnt <= '0;
    end else if (!sample) begin
      win_cnt <= '0;
      spk_cnt <= '0;
    end else begin
      win_cnt <= cur_idx + WINDOW_LOG2'(1);
      if (win_end)
        spk_cnt <= '0;
      else if (bus.spike && (spk_cnt != 9'h1FF))
        spk_cnt <= spk_cnt + 9'd1;
    end
  end

`ifdef SPIKE_DEC_ISI_EN
  logic [7:0] isi_cnt;
  logic [7:0] last_isi;
  logic       seen;

  // The first spike of a session only arms the interval; no interval exists yet.
  always_comb begin
    isi_nxt = last_isi;
    if (bus.spike && seen)
      isi_nxt = (isi_cnt == 8'hFF) ? 8'hFF : isi_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isi_cnt  <= '0;
      last_isi <= 8'hFF;
      seen     <= 1'b0;
    end else if (!sample) begin
      isi_cnt  <= '0;
      last_isi <= 8'hFF;
      seen     <= 1'b0;
    end else begin
      last_isi <= isi_nxt;
      if (bus.spike) begin
        isi_cnt <= '0;
        seen    <= 1'b1;
      end else if (isi_cnt != 8'hFF) begin
        isi_cnt <= isi_cnt + 8'd1;
      end
    end
  end
`else
  assign isi_nxt = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.valid    <= 1'b0;
      bus.rate     <= '0;
      bus.isi      <= '0;
      bus.overflow <= 1'b0;
    end else begin
      if (bus.valid && bus.ready) bus.valid <= 1'b0;
      if (win_end) begin
        if (slot_free) begin
          bus.valid <= 1'b1;
          bus.rate  <= rate_nxt;
          bus.isi   <= isi_nxt;
        end else begin
          bus.overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb/tb_spike_rate_decoder.sv - scoreboard bench for spike_rate_decoder at 16- and 256-cycle windows
module tb_spike_rate_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, sp = 1'b0, rd = 1'b0;
  int   total = 0, bad = 0;

  always #5 clk = ~clk;

  spike_rate_decoder_if bus4 ();
  spike_rate_decoder_if bus8 ();

  assign bus4.spike  = sp;
  assign bus4.enable = en;
  assign bus4.ready  = rd;
  assign bus8.spike  = sp;
  assign bus8.enable = en;
  assign bus8.ready  = rd;

  spike_rate_decoder #(.WINDOW_LOG2(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  spike_rate_decoder #(.WINDOW_LOG2(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  // Reference: spike times of the current enable session, plus a per-window-size result slot.
  int pos;
  int times[$];
  bit m_occ[2];
  bit m_ovf[2];
  int q0[$];
  int q1[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_rate(input int n);
    int c = 0;
    foreach (times[i]) if (times[i] > pos - n) c++;
    return (c > 255) ? 255 : c;
  endfunction

  function automatic int exp_isi();
`ifdef SPIKE_DEC_ISI_EN
    int d;
    if (times.size() < 2) return 255;
    d = times[times.size()-1] - times[times.size()-2];
    return (d > 255) ? 255 : d;
`else
    return 0;
`endif
  endfunction

  task automatic slot_step(input int k, input int n, input bit wend);
    int e;
    if (wend) begin
      if (!m_occ[k] || rd) begin
        m_occ[k] = 1'b1;
        e = exp_rate(n) * 256 + exp_isi();
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
      end else begin
        m_ovf[k] = 1'b1;
      end
    end else if (m_occ[k] && rd) begin
      m_occ[k] = 1'b0;
    end
  endtask

  task automatic model_reset();
    pos = 0;
    times.delete();
    q0.delete();
    q1.delete();
    m_occ[0] = 1'b0; m_occ[1] = 1'b0;
    m_ovf[0] = 1'b0; m_ovf[1] = 1'b0;
  endtask

  task automatic model_step();
    if (en) begin
      if (sp) times.push_back(pos);
      slot_step(0, 16,  (pos % 16)  == 15);
      slot_step(1, 256, (pos % 256) == 255);
      pos++;
    end else begin
      times.delete();
      pos = 0;
      slot_step(0, 16,  1'b0);
      slot_step(1, 256, 1'b0);
    end
  endtask

  task automatic cyc(input int e, input int s, input int r);
    en = (e != 0);
    sp = (s != 0);
    rd = (r != 0);
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid4"}, int'(bus4.valid), 0);
    chk({tag, "_rate4"},  int'(bus4.rate), 0);
    chk({tag, "_isi4"},   int'(bus4.isi), 0);
    chk({tag, "_ovf4"},   int'(bus4.overflow), 0);
    chk({tag, "_valid8"}, int'(bus8.valid), 0);
    chk({tag, "_rate8"},  int'(bus8.rate), 0);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
  endtask

  task automatic mon(input int k);
    logic v, o;
    logic [7:0] r, i;
    int e, qs;
    v  = (k == 0) ? bus4.valid    : bus8.valid;
    o  = (k == 0) ? bus4.overflow : bus8.overflow;
    r  = (k == 0) ? bus4.rate     : bus8.rate;
    i  = (k == 0) ? bus4.isi      : bus8.isi;
    qs = (k == 0) ? q0.size()     : q1.size();
    chk($sformatf("w%0d_valid", k), int'(v), int'(m_occ[k]));
    chk($sformatf("w%0d_overflow", k), int'(o), int'(m_ovf[k]));
    if (v) begin
      if (qs == 0) begin
        total++;
        bad++;
        $display("FAIL w%0d_result actual=valid required=no pending result at %0t", k, $time);
      end else begin
        e = (k == 0) ? q0[0] : q1[0];
        chk($sformatf("w%0d_rate", k), int'(r), e / 256);
        chk($sformatf("w%0d_isi", k), int'(i), e % 256);
        if (rd) begin
          if (k == 0) void'(q0.pop_front());
          else        void'(q1.pop_front());
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mon(0);
      mon(1);
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    rst_n = 1'b1;

    // Saturation: spike every cycle, 256-cycle window clamps at 255.
    repeat (300) cyc(1, 1, 1);
    cyc(0, 0, 1);

    // Periodic spikes every 4 cycles, then a single spike in a window.
    for (int i = 0; i < 64; i++) cyc(1, (i % 4) == 0, 1);
    cyc(0, 0, 1);
    for (int i = 0; i < 16; i++) cyc(1, i == 5, 1);
    cyc(0, 0, 1);

    // Backpressure across two windows, then release.
    for (int i = 0; i < 40; i++) cyc(1, $urandom_range(0, 1), 0);
    for (int i = 0; i < 20; i++) cyc(1, $urandom_range(0, 1), 1);

    // Enable drop at index 9, then a fresh window.
    cyc(0, 0, 1);
    for (int i = 0; i < 10; i++) cyc(1, 1, 1);
    cyc(0, 0, 1);
    for (int i = 0; i < 17; i++) cyc(1, $urandom_range(0, 1), 1);

    // Accept exactly on the window-end edge while a result is held.
    cyc(0, 0, 1);
    reset_pulse();
    for (int i = 0; i < 40; i++) cyc(1, $urandom_range(0, 1), i == 31);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1);

    // Reset mid-window with spikes active.
    for (int i = 0; i < 7; i++) cyc(1, 1, 1);
    reset_pulse();
    for (int i = 0; i < 20; i++) cyc(1, 1, 1);

    // Randomized traffic with occasional enable drops and backpressure.
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 63) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);

    for (int i = 0; i < 4; i++) cyc(0, 0, 1);
    chk("drain_w4", q0.size(), 0);
    chk("drain_w8", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
